// File: rtl/sid_voice_reg_sequencer.sv
// Timed register-write queue for one SID voice.
// CPU-side pushes of (addr, data, delay) are buffered in a FIFO and drained at the
// 1 MHz SID tick, so voice register writes land with tick-exact spacing.
module sid_voice_reg_sequencer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DELAY_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce_1m_i,
  input  logic                  wr_en_i,
  input  logic [2:0]            wr_addr_i,
  input  logic [7:0]            wr_data_i,
  input  logic [DELAY_W-1:0]    wr_delay_i,
  input  logic                  flush_i,
  input  logic [7:0]            osc_in_i,
  input  logic [7:0]            env_in_i,
  output logic [7:0]            freq_lo_o,
  output logic [7:0]            freq_hi_o,
  output logic [7:0]            pw_lo_o,
  output logic [7:0]            pw_hi_o,
  output logic [7:0]            control_o,
  output logic [7:0]            att_dec_o,
  output logic [7:0]            sus_rel_o,
  output logic                  ctrl_wr_o,
  output logic                  wr_ready_o,
  output logic [DEPTH_LOG2:0]   fifo_count_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic [7:0]            osc_rb_o,
  output logic [7:0]            env_rb_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic {StIdle, StWait} state_e;

  // FIFO storage, one array per entry field
  logic [2:0]         mem_addr  [Depth];
  logic [7:0]         mem_data  [Depth];
  logic [DELAY_W-1:0] mem_delay [Depth];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  state_e             state_q;
  logic [2:0]         cur_addr_q;
  logic [7:0]         cur_data_q;
  logic [DELAY_W-1:0] cnt_q;

  logic [7:0] freq_lo_q, freq_hi_q, pw_lo_q, pw_hi_q, control_q, att_dec_q, sus_rel_q;
  logic       ctrl_wr_q;
  logic [7:0] osc_rb_q, env_rb_q;

  logic empty, full, pop, push;

  // Handshake decode; a pop in the same clock frees a slot for a push when full
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FullCount);
    pop        = (state_q == StIdle) && !empty && !flush_i;
    wr_ready_o = !full || pop;
    push       = wr_en_i && wr_ready_o && !flush_i;
  end

  // Entry storage; no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[wr_ptr_q]  <= wr_addr_i;
      mem_data[wr_ptr_q]  <= wr_data_i;
      mem_delay[wr_ptr_q] <= wr_delay_i;
    end
  end

  // Pointer, occupancy and overflow next-state; flush overrides everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (wr_en_i && !wr_ready_o) overflow_d = 1'b1;
    end
  end

  // FIFO bookkeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Sequencer FSM with registered voice outputs and readback sampling
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      cur_data_q <= '0;
      cnt_q      <= '0;
      freq_lo_q  <= '0;
      freq_hi_q  <= '0;
      pw_lo_q    <= '0;
      pw_hi_q    <= '0;
      control_q  <= '0;
      att_dec_q  <= '0;
      sus_rel_q  <= '0;
      ctrl_wr_q  <= 1'b0;
      osc_rb_q   <= '0;
      env_rb_q   <= '0;
    end else begin
      ctrl_wr_q <= 1'b0;
      if (ce_1m_i) begin
        osc_rb_q <= osc_in_i;
        env_rb_q <= env_in_i;
      end
      if (flush_i) begin
        // In-flight entry is abandoned without writing
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (!empty) begin
              cur_addr_q <= mem_addr[rd_ptr_q];
              cur_data_q <= mem_data[rd_ptr_q];
              cnt_q      <= mem_delay[rd_ptr_q];
              state_q    <= StWait;
            end
          end
          StWait: begin
            if (ce_1m_i) begin
              if (cnt_q == '0) begin
                state_q <= StIdle;
                case (cur_addr_q)
                  3'd0: freq_lo_q <= cur_data_q;
                  3'd1: freq_hi_q <= cur_data_q;
                  3'd2: pw_lo_q   <= cur_data_q;
                  3'd3: pw_hi_q   <= cur_data_q;
                  3'd4: begin
                    control_q <= cur_data_q;
                    ctrl_wr_q <= 1'b1;
                  end
                  3'd5: att_dec_q <= cur_data_q;
                  3'd6: sus_rel_q <= cur_data_q;
                  default: ; // addr 7: delay-only entry
                endcase
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign freq_lo_o    = freq_lo_q;
  assign freq_hi_o    = freq_hi_q;
  assign pw_lo_o      = pw_lo_q;
  assign pw_hi_o      = pw_hi_q;
  assign control_o    = control_q;
  assign att_dec_o    = att_dec_q;
  assign sus_rel_o    = sus_rel_q;
  assign ctrl_wr_o    = ctrl_wr_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (count_q != '0) || (state_q == StWait);
  assign overflow_o   = overflow_q;
  assign osc_rb_o     = osc_rb_q;
  assign env_rb_o     = env_rb_q;

endmodule

// File: tb/tb_sid_voice_reg_sequencer.sv
// Directed bench for sid_voice_reg_sequencer with hand-computed expectations.
module tb_sid_voice_reg_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce_1m = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [15:0] wr_delay = '0;
  logic        flush = 1'b0;
  logic [7:0]  osc_in = '0;
  logic [7:0]  env_in = '0;
  logic [7:0]  freq_lo, freq_hi, pw_lo, pw_hi, control, att_dec, sus_rel;
  logic        ctrl_wr, wr_ready, busy, overflow;
  logic [4:0]  fifo_count;
  logic [7:0]  osc_rb, env_rb;

  int n_assert = 0;
  int n_fail   = 0;

  sid_voice_reg_sequencer #(.DEPTH_LOG2(4), .DELAY_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .ce_1m_i      (ce_1m),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_delay_i   (wr_delay),
    .flush_i      (flush),
    .osc_in_i     (osc_in),
    .env_in_i     (env_in),
    .freq_lo_o    (freq_lo),
    .freq_hi_o    (freq_hi),
    .pw_lo_o      (pw_lo),
    .pw_hi_o      (pw_hi),
    .control_o    (control),
    .att_dec_o    (att_dec),
    .sus_rel_o    (sus_rel),
    .ctrl_wr_o    (ctrl_wr),
    .wr_ready_o   (wr_ready),
    .fifo_count_o (fifo_count),
    .busy_o       (busy),
    .overflow_o   (overflow),
    .osc_rb_o     (osc_rb),
    .env_rb_o     (env_rb)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic clk();
    @(posedge clock);
    #1;
  endtask

  // One low clock then one ce_1m clock, so ticks are never adjacent
  task automatic tick();
    clk();
    ce_1m = 1'b1;
    clk();
    ce_1m = 1'b0;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d, input logic [15:0] dl);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_delay = dl;
    clk();
    wr_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    clk(); clk();
    check("rst_count", 32'(fifo_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_control", 32'(control), 0);
    check("rst_osc_rb", 32'(osc_rb), 0);
    reset = 1'b0;
    clk();

    // T1: zero-delay control write
    push(3'd4, 8'h11, 16'd0);
    check("t1_count_push", 32'(fifo_count), 1);
    check("t1_busy_push", 32'(busy), 1);
    clk();
    check("t1_count_pop", 32'(fifo_count), 0);
    check("t1_busy_wait", 32'(busy), 1);
    check("t1_control_pre", 32'(control), 0);
    tick();
    check("t1_control", 32'(control), 32'h11);
    check("t1_ctrl_wr", 32'(ctrl_wr), 1);
    check("t1_busy_done", 32'(busy), 0);
    clk();
    check("t1_ctrl_wr_fall", 32'(ctrl_wr), 0);

    // T2: delay 3 then delay 0, no drift
    push(3'd0, 8'h34, 16'd3);
    push(3'd1, 8'h12, 16'd0);
    check("t2_count", 32'(fifo_count), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t2_freq_lo_early", 32'(freq_lo), 0);
    end
    tick();
    check("t2_freq_lo_tick4", 32'(freq_lo), 32'h34);
    check("t2_freq_hi_tick4", 32'(freq_hi), 0);
    tick();
    check("t2_freq_hi_tick5", 32'(freq_hi), 32'h12);
    check("t2_busy_done", 32'(busy), 0);

    // T3: stall with a long NOP in flight, then fill the FIFO
    push(3'd7, 8'h00, 16'hFFFF);
    clk();
    for (int i = 0; i < 15; i++) push(3'd7, 8'(i), 16'd0);
    check("t3_count15", 32'(fifo_count), 15);
    check("t3_ready15", 32'(wr_ready), 1);
    push(3'd7, 8'h0F, 16'd0);
    check("t3_count16", 32'(fifo_count), 16);
    check("t3_ready16", 32'(wr_ready), 0);
    check("t3_ovf_before", 32'(overflow), 0);
    push(3'd7, 8'h10, 16'd0);
    check("t3_count17", 32'(fifo_count), 16);
    check("t3_overflow", 32'(overflow), 1);
    flush = 1'b1;
    clk();
    flush = 1'b0;
    check("t3_flush_count", 32'(fifo_count), 0);
    check("t3_flush_busy", 32'(busy), 0);
    check("t3_flush_ovf", 32'(overflow), 0);
    check("t3_flush_ready", 32'(wr_ready), 1);

    // T4: delay-only entry holds off the next write
    push(3'd7, 8'hAA, 16'd5);
    push(3'd2, 8'h80, 16'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t4_pw_lo_hold", 32'(pw_lo), 0);
    end
    check("t4_control_kept", 32'(control), 32'h11);
    check("t4_freq_lo_kept", 32'(freq_lo), 32'h34);
    tick();
    check("t4_pw_lo_tick7", 32'(pw_lo), 32'h80);

    // T5: flush mid-wait abandons the entry
    push(3'd5, 8'h09, 16'd10);
    clk();
    for (int i = 1; i <= 3; i++) tick();
    clk();
    ce_1m = 1'b1; flush = 1'b1;
    clk();
    ce_1m = 1'b0; flush = 1'b0;
    check("t5_att_dec_flush", 32'(att_dec), 0);
    check("t5_count_flush", 32'(fifo_count), 0);
    check("t5_busy_flush", 32'(busy), 0);
    for (int i = 0; i < 12; i++) tick();
    check("t5_att_dec_later", 32'(att_dec), 0);
    // flush with wr_en: push discarded
    wr_en = 1'b1; flush = 1'b1; wr_addr = 3'd5; wr_data = 8'h09; wr_delay = 16'd0;
    clk();
    wr_en = 1'b0; flush = 1'b0;
    check("t5_fw_count", 32'(fifo_count), 0);
    check("t5_fw_overflow", 32'(overflow), 0);
    check("t5_fw_busy", 32'(busy), 0);
    // flush on the apply clock
    push(3'd5, 8'h09, 16'd0);
    clk();
    clk();
    ce_1m = 1'b1; flush = 1'b1;
    clk();
    ce_1m = 1'b0; flush = 1'b0;
    check("t5_apply_flush", 32'(att_dec), 0);
    check("t5_apply_busy", 32'(busy), 0);
    push(3'd6, 8'h77, 16'd0);
    tick();
    check("t5_sus_rel", 32'(sus_rel), 32'h77);

    // T6: readback only updates on ce_1m
    osc_in = 8'hA5; env_in = 8'h3C;
    clk();
    check("t6_osc_hold", 32'(osc_rb), 0);
    check("t6_env_hold", 32'(env_rb), 0);
    ce_1m = 1'b1;
    clk();
    ce_1m = 1'b0;
    check("t6_osc_upd", 32'(osc_rb), 32'hA5);
    check("t6_env_upd", 32'(env_rb), 32'h3C);
    osc_in = 8'h5A;
    clk(); clk();
    check("t6_osc_hold2", 32'(osc_rb), 32'hA5);
    tick();
    check("t6_osc_upd2", 32'(osc_rb), 32'h5A);

    // Reset in the middle of a wait: no apply, everything cleared
    push(3'd4, 8'h22, 16'd2);
    clk();
    tick();
    reset = 1'b1;
    clk();
    reset = 1'b0;
    check("rw_control", 32'(control), 0);
    check("rw_busy", 32'(busy), 0);
    check("rw_count", 32'(fifo_count), 0);
    check("rw_sus_rel", 32'(sus_rel), 0);
    check("rw_osc_rb", 32'(osc_rb), 0);
    for (int i = 0; i < 4; i++) tick();
    check("rw_control_later", 32'(control), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
